// File: rtl/mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_pkg : shared constants, FSM state type and lowest-set-bit helper       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mux_pkg;

  localparam int NUM_CH        = 8;
  localparam int SEL_W         = 3;
  localparam int DWELL_DEFAULT = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Index of the lowest set bit; 0 for an empty mask.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_8_1_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_8_1_scan_if : scan-mux control, data and selected-channel bundle       |
// | Revision: 1.0   (par/par_valid present with MUX_FRAME_PARITY_EN)           |
// +----------------------------------------------------------------------------+
interface mux_8_1_scan_if;
  import mux_pkg::*;

  logic              en;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] d;
  logic              o;
  logic [SEL_W-1:0]  sel;
  logic              valid;
  logic              frame_start;
`ifdef MUX_FRAME_PARITY_EN
  logic              par;
  logic              par_valid;
`endif

  modport master (
    output en, ch_mask, d,
`ifdef MUX_FRAME_PARITY_EN
    input  par, par_valid,
`endif
    input  o, sel, valid, frame_start
  );

  modport slave (
    input  en, ch_mask, d,
`ifdef MUX_FRAME_PARITY_EN
    output par, par_valid,
`endif
    output o, sel, valid, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/ch_next_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ch_next_sel : next higher set bit of mask above sel, else wrap to lowest   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ch_next_sel
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [SEL_W-1:0]  next_sel_o,
  output logic              wrap_o
);

  // Descending scan so the last hit is the nearest set bit above sel_i.
  always_comb begin
    next_sel_o = lowest_set(mask_i);
    wrap_o     = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(sel_i))) begin
        next_sel_o = SEL_W'(i);
        wrap_o     = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_8_1_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_8_1_scan : 8:1 scanning mux, DWELL cycles per enabled channel          |
// | Revision: 1.0   (optional frame parity: MUX_FRAME_PARITY_EN)               |
// +----------------------------------------------------------------------------+
module mux_8_1_scan
  import mux_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  mux_8_1_scan_if.slave bus
);

  localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

  state_t            state_q;
  logic [NUM_CH-1:0] mask_q;
  logic [SEL_W-1:0]  sel_q;
  logic              o_q;
  logic              valid_q;
  logic              fs_q;
  logic [7:0]        cnt_q;

  logic [SEL_W-1:0]  w_next_sel;
  logic [SEL_W-1:0]  w_first_sel;
  logic              w_wrap;
  logic              w_dwell_done;

  ch_next_sel u_next (
    .mask_i     (mask_q),
    .sel_i      (sel_q),
    .next_sel_o (w_next_sel),
    .wrap_o     (w_wrap)
  );

  // A new frame always begins on the lowest channel of the live mask.
  assign w_first_sel  = lowest_set(bus.ch_mask);
  assign w_dwell_done = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      sel_q   <= '0;
      o_q     <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.en && (|bus.ch_mask)) begin
            state_q <= ST_SCAN;
            mask_q  <= bus.ch_mask;
            sel_q   <= w_first_sel;
            o_q     <= bus.d[w_first_sel];
            valid_q <= 1'b1;
            fs_q    <= 1'b1;
            cnt_q   <= '0;
          end else begin
            mask_q  <= '0;
            sel_q   <= '0;
            o_q     <= 1'b0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            cnt_q   <= '0;
          end
        end
        ST_SCAN: begin
          // en low wins over any pending wrap or dwell expiry.
          if (!bus.en || (w_dwell_done && w_wrap && !(|bus.ch_mask))) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            sel_q   <= '0;
            o_q     <= 1'b0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            cnt_q   <= '0;
          end else if (w_dwell_done && w_wrap) begin
            mask_q  <= bus.ch_mask;
            sel_q   <= w_first_sel;
            o_q     <= bus.d[w_first_sel];
            fs_q    <= 1'b1;
            cnt_q   <= '0;
          end else if (w_dwell_done) begin
            sel_q   <= w_next_sel;
            o_q     <= bus.d[w_next_sel];
            fs_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            o_q     <= bus.d[sel_q];
            fs_q    <= 1'b0;
            cnt_q   <= cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o           = o_q;
  assign bus.sel         = sel_q;
  assign bus.valid       = valid_q;
  assign bus.frame_start = fs_q;

`ifdef MUX_FRAME_PARITY_EN
  logic w_frame_end;
  logic acc_q;
  logic par_q;
  logic par_valid_q;

  assign w_frame_end = (state_q == ST_SCAN) && (!bus.en || (w_dwell_done && w_wrap));

  // acc_q folds in each o once its cycle has been presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= 1'b0;
      par_q       <= 1'b0;
      par_valid_q <= 1'b0;
    end else if (w_frame_end) begin
      par_q       <= acc_q ^ o_q;
      par_valid_q <= 1'b1;
      acc_q       <= 1'b0;
    end else begin
      par_valid_q <= 1'b0;
      acc_q       <= (state_q == ST_SCAN) ? (acc_q ^ o_q) : 1'b0;
    end
  end

  assign bus.par       = par_q;
  assign bus.par_valid = par_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_8_1_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mux_8_1_scan : vector table, directed sequences and random vs model     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mux_8_1_scan;
  import mux_pkg::*;

  localparam int DWELL = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux_8_1_scan_if bus ();

  mux_8_1_scan #(.DWELL(DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a frame is the list of enabled channels, each held DWELL cycles.
  bit         m_active;
  int         m_list[$];
  int         m_pos;
  int         m_hold;
  logic       e_o, e_valid, e_fs;
  logic [2:0] e_sel;
`ifdef MUX_FRAME_PARITY_EN
  logic       m_xor, e_par, e_pv;
`endif

  task automatic model_idle();
    m_active = 0; m_list.delete(); m_pos = 0; m_hold = 0;
    e_valid = 0; e_sel = '0; e_fs = 0;
  endtask

  task automatic model_start(input logic [7:0] m);
    m_list.delete();
    for (int n = 0; n < 8; n++) if (m[n]) m_list.push_back(n);
    m_active = 1; m_pos = 0; m_hold = 0;
    e_valid = 1; e_fs = 1; e_sel = 3'(m_list[0]);
  endtask

  task automatic model_close();
`ifdef MUX_FRAME_PARITY_EN
    e_par = m_xor; e_pv = 1; m_xor = 0;
`endif
  endtask

  task automatic model_update(input logic en, input logic [7:0] m, input logic [7:0] dv);
`ifdef MUX_FRAME_PARITY_EN
    e_pv = 0;
`endif
    if (!m_active) begin
      if (en && m != 0) model_start(m);
      else model_idle();
    end else if (!en) begin
      model_close(); model_idle();
    end else begin
      e_fs = 0;
      m_hold++;
      if (m_hold == DWELL) begin
        m_hold = 0;
        m_pos++;
        if (m_pos == m_list.size()) begin
          model_close();
          if (m != 0) model_start(m);
          else model_idle();
        end else begin
          e_sel = 3'(m_list[m_pos]);
        end
      end
    end
    e_o = e_valid ? dv[e_sel] : 1'b0;
`ifdef MUX_FRAME_PARITY_EN
    if (e_valid) m_xor ^= e_o;
`endif
  endtask

  task automatic model_reset();
    model_idle();
    e_o = 0;
`ifdef MUX_FRAME_PARITY_EN
    m_xor = 0; e_par = 0; e_pv = 0;
`endif
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("valid", 8'(bus.valid), 8'(e_valid));
    chk("sel", 8'(bus.sel), 8'(e_sel));
    chk("o", 8'(bus.o), 8'(e_o));
    chk("frame_start", 8'(bus.frame_start), 8'(e_fs));
`ifdef MUX_FRAME_PARITY_EN
    chk("par_valid", 8'(bus.par_valid), 8'(e_pv));
    chk("par", 8'(bus.par), 8'(e_par));
`endif
  endtask

  // Drive inputs, predict, clock once, compare #1 after the edge.
  task automatic cycle(input logic en, input logic [7:0] m, input logic [7:0] dv);
    bus.en = en; bus.ch_mask = m; bus.d = dv;
    model_update(en, m, dv);
    @(posedge clk);
    #1;
    chk_model();
  endtask

  typedef struct {
    logic       en;
    logic [7:0] mask;
    logic [7:0] d;
    logic       valid;
    logic [2:0] sel;
    logic       o;
    logic       fs;
  } vec_t;

  vec_t tbl[8];
  int   fs_cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    tbl[0] = '{1'b1, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h80, 8'h80, 1'b1, 3'd7, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 8'h49, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'h48, 8'h08, 1'b1, 3'd3, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 8'hFF, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h30, 8'hEF, 1'b1, 3'd4, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'h06, 8'h02, 1'b1, 3'd1, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 8'h01, 8'h01, 1'b1, 3'd0, 1'b1, 1'b1};

    rst = 1'b1; bus.en = 1'b0; bus.ch_mask = '0; bus.d = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_model();
    rst = 1'b0;

    // Entry behaviour from IDLE for each vector.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 8'h00);
      cycle(tbl[i].en, tbl[i].mask, tbl[i].d);
      chk("tbl_valid", 8'(bus.valid), 8'(tbl[i].valid));
      chk("tbl_sel", 8'(bus.sel), 8'(tbl[i].sel));
      chk("tbl_o", 8'(bus.o), 8'(tbl[i].o));
      chk("tbl_fs", 8'(bus.frame_start), 8'(tbl[i].fs));
    end

    // Full mask: sel walks 0..7, one frame_start per 40 cycles.
    cycle(1'b0, 8'h00, 8'h00);
    fs_cnt = 0;
    for (int k = 1; k <= 80; k++) begin
      cycle(1'b1, 8'hFF, 8'hAA);
      if (bus.frame_start) fs_cnt++;
      if (k == 6)  begin chk("full_sel1", 8'(bus.sel), 8'd1); chk("full_o1", 8'(bus.o), 8'd1); end
      if (k == 36) chk("full_sel7", 8'(bus.sel), 8'd7);
      if (k == 41) chk("full_wrap_fs", 8'(bus.frame_start), 8'd1);
    end
    chk("full_fs_count", 8'(fs_cnt), 8'd2);

    // Sparse mask 0,3,6 then wrap.
    cycle(1'b0, 8'h00, 8'h00);
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b1, 8'h49, 8'($urandom));
      if (k == 6)  begin chk("sparse_sel3", 8'(bus.sel), 8'd3); chk("sparse_fs3", 8'(bus.frame_start), 8'd0); end
      if (k == 11) chk("sparse_sel6", 8'(bus.sel), 8'd6);
      if (k == 16) begin chk("sparse_sel0", 8'(bus.sel), 8'd0); chk("sparse_fs0", 8'(bus.frame_start), 8'd1); end
    end

    // Mask shrinks mid-frame: takes effect only after the wrap.
    cycle(1'b0, 8'h00, 8'h00);
    for (int k = 1; k <= 50; k++) begin
      cycle(1'b1, (k < 12) ? 8'hFF : 8'h01, 8'($urandom));
      if (k == 36) chk("shrink_sel7", 8'(bus.sel), 8'd7);
      if (k == 41) chk("shrink_wrap_fs", 8'(bus.frame_start), 8'd1);
      if (k == 44) chk("shrink_no_fs", 8'(bus.frame_start), 8'd0);
      if (k == 46) begin chk("shrink_sel0", 8'(bus.sel), 8'd0); chk("shrink_fs_single", 8'(bus.frame_start), 8'd1); end
    end

    // en dropped at dwell count 2 of channel 4, then restart.
    cycle(1'b0, 8'h00, 8'h00);
    for (int k = 1; k <= 23; k++) cycle(1'b1, 8'hFF, 8'hFF);
    chk("drop_sel4", 8'(bus.sel), 8'd4);
    cycle(1'b0, 8'hFF, 8'hFF);
    chk("drop_valid", 8'(bus.valid), 8'd0);
    chk("drop_o", 8'(bus.o), 8'd0);
    cycle(1'b1, 8'h30, 8'hFF);
    chk("restart_sel", 8'(bus.sel), 8'd4);
    chk("restart_fs", 8'(bus.frame_start), 8'd1);

    // Asynchronous reset mid-dwell, observed before the next edge.
    cycle(1'b1, 8'h30, 8'hFF);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_model();
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 8'h00, 8'hFF);
      chk("zero_mask_valid", 8'(bus.valid), 8'd0);
    end
    cycle(1'b1, 8'hFF, 8'hFF);
    chk("post_rst_fs", 8'(bus.frame_start), 8'd1);

`ifdef MUX_FRAME_PARITY_EN
    cycle(1'b0, 8'h00, 8'h00);
    for (int k = 1; k <= 80; k++) begin
      cycle(1'b1, 8'h0F, 8'h07);
      if (k == 1) chk("par_first_pv", 8'(bus.par_valid), 8'd0);
      if (k == 21 || k == 41 || k == 61) begin
        chk("par_pv", 8'(bus.par_valid), 8'd1);
        chk("par_val", 8'(bus.par), 8'd1);
      end
    end
`endif

    // Randomised run against the model.
    begin
      logic       ren;
      logic [7:0] rmask;
      rmask = 8'hFF;
      for (int k = 0; k < 1500; k++) begin
        ren = ($urandom_range(0, 24) != 0);
        if ($urandom_range(0, 29) == 0) begin
          case ($urandom_range(0, 3))
            0: rmask = 8'h00;
            1: rmask = 8'(1 << $urandom_range(0, 7));
            default: rmask = 8'($urandom);
          endcase
        end
        cycle(ren, rmask, 8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
